pcileech_tlps128_pkt_fifo: RTL
==============================

# pcileech_tlps128_pkt_fifo

Store-and-forward packet FIFO on `clk_pcie` between a non-backpressurable TLP producer (`IfAXIS128.sink_lite`, e.g. the BAR response path) and one input of the TX sink mux. Only complete TLPs are exposed: `has_data` asserts once at least one whole packet is committed. The output meets the mux's 1-clock `tready`→data latency rule. Packets that do not fit, or that are truncated, are dropped atomically.

## Interface
- `DEPTH_LOG2`, 6: buffer depth = 2^DEPTH_LOG2 beats of 128 bit.
- `clk_pcie`  in  1  sole clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `tlps_in`  IfAXIS128.sink_lite  bundle  `tdata[127:0]`, `tkeepdw[3:0]`, `tlast`, `tuser[8:0]` (`tuser[0]` = first beat), `tvalid`; no backpressure.
- `tlps_out`  IfAXIS128.source  bundle  `tdata`, `tkeepdw`, `tlast`, `tuser`, `tvalid`, `has_data` out; `tready` in.
- `drop_count`  out  16  saturating count of dropped packets (see Configuration).

## Operation
- Pointers `wr_ptr`, `wr_commit`, `rd_ptr` are DEPTH_LOG2+1 bits; occupancy = `wr_ptr - rd_ptr` modulo 2^(DEPTH_LOG2+1); full when occupancy == 2^DEPTH_LOG2. Wrap-around is implicit in the modulo arithmetic.
- Write FSM states:
  - IDLE: waiting for a first beat.
    - `tvalid && tuser[0]`: write the beat and go to PKT.
    - If that beat also has `tlast`, commit immediately and stay in IDLE.
    - `tvalid && !tuser[0]`: orphan beat; discard and count one drop.
  - PKT: write each valid beat and advance `wr_ptr`.
    - `tlast`: `wr_commit <= wr_ptr+1`, increment `pkt_count`, go to IDLE.
    - `tuser[0]` seen mid-packet (truncation): rewind `wr_ptr` to `wr_commit`, count one drop, then treat the beat as a new first beat.
    - Valid beat while full: rewind `wr_ptr` to `wr_commit`, count one drop, go to DROP.
  - DROP: discard beats until `tlast`, then go to IDLE. A `tuser[0]` beat in DROP leaves DROP and is handled as in IDLE.
- Read side:
  - `rd_en = tready && (rd_ptr != wr_commit)`.
  - On `rd_en`, the RAM is read and `rd_ptr` increments.
  - Only committed data is ever readable.
- `pkt_count` (DEPTH_LOG2+1 bits):
  - +1 on commit.
  - −1 on an output beat where `tvalid && tlast`.
  - Both in the same cycle: unchanged.
- `has_data = (pkt_count != 0)`. It stays high until the final `tlast` beat of the last committed packet has been presented.
- Stored entry is {tuser, tlast, tkeepdw, tdata}, 142 bits, passed through unmodified.

## Timing
- Reset (`rst_n` low at a clock edge):
  - All pointers, `pkt_count`, FSM (→IDLE), `tlps_out.tvalid`, `has_data` and `drop_count` go to 0.
  - The data outputs `tdata`, `tkeepdw`, `tlast`, `tuser` also go to 0.
  - Any packet in flight or stored is lost.
- Commit latency: `tlast` written in cycle n → `wr_commit`/`pkt_count` update at end of n → `has_data` high in n+1.
- Read latency: `rd_en` in cycle n → `tlps_out.tvalid` high with data in n+1. `tvalid` is exactly `rd_en` registered.
- With `tready` held high, back-to-back beats are produced one per cycle, with no bubble inside a packet.
- When the last readable beat was read in cycle n and `tready` stays high, `tvalid` deasserts in n+2 unless a commit occurred in n.
- Write throughput is 1 beat/cycle, including a read in the same cycle. A read freeing an entry in cycle n makes it usable by the write in n+1, not n.
- Counters:
  - A packet of more than 2^DEPTH_LOG2 beats is always dropped.
  - `drop_count` saturates at 0xFFFF.

## Configuration
- `PCILEECH_TLPS_PKTFIFO_STATS_EN` defined: the `drop_count` register is implemented as above.
- Not defined: `drop_count` is constant 0 and no counter logic is synthesised. Drop behaviour itself is identical in both cases.

## Structure
- Shared package `pcileech_tlps_pkg`:
  - `tlps128_beat_t` packed struct {tuser[8:0], tlast, tkeepdw[3:0], tdata[127:0]}.
  - Localparam `TLPS128_BEAT_W = 142`.
- Sub-module `pcileech_tlps128_pkt_fifo_ram`: simple dual-port RAM, 2^DEPTH_LOG2 × `TLPS128_BEAT_W`, synchronous write, registered 1-cycle read. Infers BRAM.
- FSM, pointers and counters stay in the top module.

## Test plan
- Single 3-beat packet (`tkeepdw` 1111/1111/0111), `tready` high:
  - `has_data` rises 1 cycle after the `tlast` write.
  - 3 beats out on consecutive cycles, bit-exact.
  - `has_data` falls the cycle after the `tlast` beat is output.
- Fill test (DEPTH_LOG2=4) with 4-beat packets and `tready` low:
  - 4 packets accepted.
  - 5th packet dropped whole; `drop_count`=1.
  - Draining outputs exactly 16 beats.
- Truncation: `tuser[0]` reasserted on beat 2 of a 4-beat packet:
  - First packet discarded; second stored intact; `drop_count`=1.
- Simultaneous commit and output `tlast` in the same cycle with `pkt_count`=1: `pkt_count` stays 1 and `has_data` stays high.
- Wrap: 100 random packets (1–5 beats) with random `tready`: output stream equals the non-dropped input stream, and pointers wrap correctly.
- `rst_n` low for 1 cycle mid-packet on both sides:
  - Next cycle `tvalid`=0, `has_data`=0, `drop_count`=0.
  - A subsequent 1-beat packet passes through.

Source files
------------

// File: rtl/pcileech_tlps_pkg.sv
// ============================================================================
// Package    : pcileech_tlps_pkg
// Description: Shared beat format and helpers for the 128-bit TLP stream path.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcileech_tlps_pkg;

  localparam int TLPS128_BEAT_W = 142;

  typedef struct packed {
    logic [8:0]   tuser;
    logic         tlast;
    logic [3:0]   tkeepdw;
    logic [127:0] tdata;
  } tlps128_beat_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PKT  = 2'd1,
    S_DROP = 2'd2
  } pktfifo_wr_state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pcileech_tlps128_pkt_fifo_ram.sv
// ============================================================================
// Module     : pcileech_tlps128_pkt_fifo_ram
// Description: Simple dual-port beat RAM, synchronous write, registered read.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcileech_tlps128_pkt_fifo_ram
  import pcileech_tlps_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [DEPTH_LOG2-1:0] i_wr_addr,
  input  tlps128_beat_t         i_wr_data,
  input  logic                  i_rd_en,
  input  logic [DEPTH_LOG2-1:0] i_rd_addr,
  output tlps128_beat_t         o_rd_data
);

  tlps128_beat_t r_mem [0:(1<<DEPTH_LOG2)-1];
  tlps128_beat_t r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Output register reset maps onto the BRAM output-register reset pin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/pcileech_tlps128_pkt_fifo.sv
// ============================================================================
// Module     : pcileech_tlps128_pkt_fifo
// Description: Store-and-forward TLP packet FIFO; only whole packets are
//              exposed, overflowing/truncated packets are dropped atomically.
//              Define PCILEECH_TLPS_PKTFIFO_STATS_EN to implement o_drop_count.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcileech_tlps128_pkt_fifo
  import pcileech_tlps_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic         clk_pcie,
  input  logic         rst_n,
  input  logic [127:0] i_tlps_in_tdata,
  input  logic [3:0]   i_tlps_in_tkeepdw,
  input  logic         i_tlps_in_tlast,
  input  logic [8:0]   i_tlps_in_tuser,
  input  logic         i_tlps_in_tvalid,
  output logic [127:0] o_tlps_out_tdata,
  output logic [3:0]   o_tlps_out_tkeepdw,
  output logic         o_tlps_out_tlast,
  output logic [8:0]   o_tlps_out_tuser,
  output logic         o_tlps_out_tvalid,
  output logic         o_tlps_out_has_data,
  input  logic         i_tlps_out_tready,
  output logic [15:0]  o_drop_count
);

  localparam int                 c_PTR_W    = DEPTH_LOG2 + 1;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [c_PTR_W-1:0] c_FULL_OCC = {1'b1, {DEPTH_LOG2{1'b0}}};

  pktfifo_wr_state_t     r_state, w_state_nxt;
  logic [c_PTR_W-1:0]    r_wr_ptr, r_wr_commit, r_rd_ptr, r_pkt_count;
  logic [c_PTR_W-1:0]    w_wr_ptr_nxt;
  logic [DEPTH_LOG2-1:0] w_wr_addr;
  logic                  w_wr_en, w_commit, w_sof, w_rd_en, w_out_last;
  logic [1:0]            w_drop_inc;
  logic                  r_tvalid;
  tlps128_beat_t         w_wr_beat, w_rd_beat;

  assign w_sof     = i_tlps_in_tuser[0];
  assign w_wr_beat = '{tuser: i_tlps_in_tuser, tlast: i_tlps_in_tlast,
                       tkeepdw: i_tlps_in_tkeepdw, tdata: i_tlps_in_tdata};

  // A first beat always restarts from the committed pointer; in PKT this
  // also discards the truncated packet already partially written.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_en      = 1'b0;
    w_wr_ptr_nxt = r_wr_ptr;
    w_wr_addr    = r_wr_ptr[DEPTH_LOG2-1:0];
    w_commit     = 1'b0;
    w_drop_inc   = 2'd0;
    if (i_tlps_in_tvalid) begin
      if (w_sof) begin
        if (r_state == S_PKT) begin
          w_drop_inc = 2'd1;
        end
        w_wr_addr = r_wr_commit[DEPTH_LOG2-1:0];
        if ((r_wr_commit - r_rd_ptr) == c_FULL_OCC) begin
          w_drop_inc   = w_drop_inc + 2'd1;
          w_wr_ptr_nxt = r_wr_commit;
          w_state_nxt  = i_tlps_in_tlast ? S_IDLE : S_DROP;
        end else begin
          w_wr_en      = 1'b1;
          w_wr_ptr_nxt = r_wr_commit + c_PTR_ONE;
          w_commit     = i_tlps_in_tlast;
          w_state_nxt  = i_tlps_in_tlast ? S_IDLE : S_PKT;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            w_drop_inc = 2'd1;
          end
          S_PKT: begin
            if ((r_wr_ptr - r_rd_ptr) == c_FULL_OCC) begin
              w_drop_inc   = 2'd1;
              w_wr_ptr_nxt = r_wr_commit;
              w_state_nxt  = i_tlps_in_tlast ? S_IDLE : S_DROP;
            end else begin
              w_wr_en      = 1'b1;
              w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
              w_commit     = i_tlps_in_tlast;
              w_state_nxt  = i_tlps_in_tlast ? S_IDLE : S_PKT;
            end
          end
          S_DROP: begin
            if (i_tlps_in_tlast) begin
              w_state_nxt = S_IDLE;
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
          end
        endcase
      end
    end
  end

  assign w_rd_en    = i_tlps_out_tready && (r_rd_ptr != r_wr_commit);
  assign w_out_last = r_tvalid && w_rd_beat.tlast;

  always_ff @(posedge clk_pcie) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_rd_ptr    <= '0;
      r_pkt_count <= '0;
      r_tvalid    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      if (w_commit) begin
        r_wr_commit <= w_wr_ptr_nxt;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      r_tvalid <= w_rd_en;
      case ({w_commit, w_out_last})
        2'b10:   r_pkt_count <= r_pkt_count + c_PTR_ONE;
        2'b01:   r_pkt_count <= r_pkt_count - c_PTR_ONE;
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  pcileech_tlps128_pkt_fifo_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk       (clk_pcie),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_beat),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr[DEPTH_LOG2-1:0]),
    .o_rd_data (w_rd_beat)
  );

  assign o_tlps_out_tdata    = w_rd_beat.tdata;
  assign o_tlps_out_tkeepdw  = w_rd_beat.tkeepdw;
  assign o_tlps_out_tlast    = w_rd_beat.tlast;
  assign o_tlps_out_tuser    = w_rd_beat.tuser;
  assign o_tlps_out_tvalid   = r_tvalid;
  assign o_tlps_out_has_data = (r_pkt_count != '0);

`ifdef PCILEECH_TLPS_PKTFIFO_STATS_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge clk_pcie) begin
    if (!rst_n) begin
      r_drop_count <= '0;
    end else begin
      r_drop_count <= sat_add16(r_drop_count, w_drop_inc);
    end
  end

  assign o_drop_count = r_drop_count;
`else
  logic w_unused_drop_inc;
  assign w_unused_drop_inc = ^w_drop_inc;
  assign o_drop_count      = 16'd0;
`endif

endmodule

`default_nettype wire
